// File: rtl/v_hier_defs.sv
// Shared definitions for the serial driver: FSM encodings and counter widths.
package v_hier_defs;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    localparam int GAP_CW = 4;

    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/v_hier_fifo2.sv
// Two-entry register FIFO; push when full and pop when empty are ignored.
module v_hier_fifo2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push && (count_q != 2'd2);
    assign pop_ok  = pop && (count_q != 2'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_ok) wr_ptr_q <= ~wr_ptr_q;
            if (pop_ok)  rd_ptr_q <= ~rd_ptr_q;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/v_hier_serdrv.sv
// Parallel-to-serial driver feeding the 1-bit signed leaf stage, with a
// two-word input buffer and a programmable idle gap between words.
module v_hier_serdrv
    import v_hier_defs::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 0,
    parameter int GAP       = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_data,
    output logic                    a_out,
    output logic                    frame,
    output logic                    last,
    output logic                    busy
);

    localparam int CW = cnt_width(WIDTH);

    state_e            state_q, state_d;
    logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [GAP_CW-1:0] gap_cnt_q, gap_cnt_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic              a_out_q, a_out_d;
    logic              frame_q, frame_d;
    logic              last_q, last_d;

    logic [1:0]        fifo_count;
    logic [WIDTH-1:0]  fifo_dout;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_nempty;

    assign in_ready    = !reset && (fifo_count != 2'd2);
    assign fifo_push   = in_valid && in_ready;
    assign fifo_nempty = (fifo_count != 2'd0);

    v_hier_fifo2 #(
        .WIDTH(WIDTH)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .push (fifo_push),
        .pop  (fifo_pop),
        .din  (in_data),
        .dout (fifo_dout),
        .count(fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            shreg_q   <= '0;
            a_out_q   <= 1'b0;
            frame_q   <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            shreg_q   <= shreg_d;
            a_out_q   <= a_out_d;
            frame_q   <= frame_d;
            last_q    <= last_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        shreg_d   = shreg_q;
        fifo_pop  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (fifo_nempty) begin
                    fifo_pop  = 1'b1;
                    shreg_d   = fifo_dout;
                    bit_cnt_d = CW'(WIDTH - 1);
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shreg_d = (MSB_FIRST != 0) ? (shreg_q << 1) : (shreg_q >> 1);
                if (bit_cnt_q != '0) begin
                    bit_cnt_d = bit_cnt_q - CW'(1);
                end else if (GAP > 0) begin
                    gap_cnt_d = GAP_CW'(GAP - 1);
                    state_d   = ST_GAP;
                end else if (fifo_nempty) begin
                    // Zero gap: reload in place so words run without a bubble.
                    fifo_pop  = 1'b1;
                    shreg_d   = fifo_dout;
                    bit_cnt_d = CW'(WIDTH - 1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q != '0) begin
                    gap_cnt_d = gap_cnt_q - GAP_CW'(1);
                end else if (fifo_nempty) begin
                    fifo_pop  = 1'b1;
                    shreg_d   = fifo_dout;
                    bit_cnt_d = CW'(WIDTH - 1);
                    state_d   = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Serial outputs are computed from next-state values so they can be
    // registered without adding a cycle of latency.
    always_comb begin
        a_out_d = 1'b0;
        frame_d = 1'b0;
        last_d  = 1'b0;
        if (state_d == ST_SHIFT) begin
            frame_d = 1'b1;
            last_d  = (bit_cnt_d == '0);
            a_out_d = (MSB_FIRST != 0) ? shreg_d[WIDTH-1] : shreg_d[0];
        end
    end

    assign a_out = a_out_q;
    assign frame = frame_q;
    assign last  = last_q;
    assign busy  = (state_q != ST_IDLE) || (fifo_count != 2'd0);

endmodule

// File: tb/tb_v_hier_serdrv.sv
// Directed self-checking bench for v_hier_serdrv across four parameter sets.
module tb_v_hier_serdrv;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // A: WIDTH 8, LSB first, GAP 1
    logic a_valid, a_ready, a_sout, a_frame, a_last, a_busy;
    logic signed [7:0] a_data;
    // B: WIDTH 8, MSB first, GAP 3
    logic b_valid, b_ready, b_sout, b_frame, b_last, b_busy;
    logic signed [7:0] b_data;
    // C: WIDTH 8, LSB first, GAP 0
    logic c_valid, c_ready, c_sout, c_frame, c_last, c_busy;
    logic signed [7:0] c_data;
    // D: WIDTH 1, GAP 0
    logic d_valid, d_ready, d_sout, d_frame, d_last, d_busy;
    logic signed [0:0] d_data;

    v_hier_serdrv #(.WIDTH(8), .MSB_FIRST(0), .GAP(1)) dut_a (
        .clk(clk), .reset(reset), .in_valid(a_valid), .in_ready(a_ready),
        .in_data(a_data), .a_out(a_sout), .frame(a_frame), .last(a_last), .busy(a_busy));
    v_hier_serdrv #(.WIDTH(8), .MSB_FIRST(1), .GAP(3)) dut_b (
        .clk(clk), .reset(reset), .in_valid(b_valid), .in_ready(b_ready),
        .in_data(b_data), .a_out(b_sout), .frame(b_frame), .last(b_last), .busy(b_busy));
    v_hier_serdrv #(.WIDTH(8), .MSB_FIRST(0), .GAP(0)) dut_c (
        .clk(clk), .reset(reset), .in_valid(c_valid), .in_ready(c_ready),
        .in_data(c_data), .a_out(c_sout), .frame(c_frame), .last(c_last), .busy(c_busy));
    v_hier_serdrv #(.WIDTH(1), .MSB_FIRST(0), .GAP(0)) dut_d (
        .clk(clk), .reset(reset), .in_valid(d_valid), .in_ready(d_ready),
        .in_data(d_data), .a_out(d_sout), .frame(d_frame), .last(d_last), .busy(d_busy));

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (a_sout !== 1'b0)  begin errors++; $display("FAIL reset a_out got %b exp 0", a_sout); end
        checks++; if (a_frame !== 1'b0) begin errors++; $display("FAIL reset frame got %b exp 0", a_frame); end
        checks++; if (a_last !== 1'b0)  begin errors++; $display("FAIL reset last got %b exp 0", a_last); end
        checks++; if (a_busy !== 1'b0)  begin errors++; $display("FAIL reset busy got %b exp 0", a_busy); end
        checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL reset in_ready got %b exp 0", a_ready); end
        checks++; if (d_ready !== 1'b0) begin errors++; $display("FAIL reset d in_ready got %b exp 0", d_ready); end
        reset = 1'b0;
        #1;
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL post-reset in_ready got %b exp 1", a_ready); end
        checks++; if (c_ready !== 1'b1) begin errors++; $display("FAIL post-reset c in_ready got %b exp 1", c_ready); end
    endtask

    task automatic test_lsb_first();
        logic [7:0] seq;
        logic ef, el, eb, ebusy;
        seq = 8'b1000_0001;
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            ef    = (c >= 2 && c <= 9);
            el    = (c == 9);
            eb    = ef ? seq[7-(c-2)] : 1'b0;
            ebusy = (c >= 1 && c <= 10);
            checks++; if (a_frame !== ef)   begin errors++; $display("FAIL lsb frame c=%0d got %b exp %b", c, a_frame, ef); end
            checks++; if (a_last !== el)    begin errors++; $display("FAIL lsb last c=%0d got %b exp %b", c, a_last, el); end
            checks++; if (a_sout !== eb)    begin errors++; $display("FAIL lsb a_out c=%0d got %b exp %b", c, a_sout, eb); end
            checks++; if (a_busy !== ebusy) begin errors++; $display("FAIL lsb busy c=%0d got %b exp %b", c, a_busy, ebusy); end
            if (c == 0) begin
                checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL lsb in_ready got %b exp 1", a_ready); end
                a_valid = 1'b1;
                a_data  = 8'sh81;
            end else begin
                a_valid = 1'b0;
            end
        end
    endtask

    task automatic test_msb_gap();
        logic [15:0] seq;
        logic ef, el, eb, ebusy;
        int k;
        seq = 16'b1001_0110_0011_1100;
        for (int c = 0; c < 26; c++) begin
            @(negedge clk);
            ef    = (c >= 2 && c <= 9) || (c >= 13 && c <= 20);
            el    = (c == 9) || (c == 20);
            k     = (c <= 9) ? (c - 2) : (c - 13 + 8);
            eb    = ef ? seq[15-k] : 1'b0;
            ebusy = (c >= 1 && c <= 23);
            checks++; if (b_frame !== ef)   begin errors++; $display("FAIL msbgap frame c=%0d got %b exp %b", c, b_frame, ef); end
            checks++; if (b_last !== el)    begin errors++; $display("FAIL msbgap last c=%0d got %b exp %b", c, b_last, el); end
            checks++; if (b_sout !== eb)    begin errors++; $display("FAIL msbgap a_out c=%0d got %b exp %b", c, b_sout, eb); end
            checks++; if (b_busy !== ebusy) begin errors++; $display("FAIL msbgap busy c=%0d got %b exp %b", c, b_busy, ebusy); end
            if (c == 0) begin
                b_valid = 1'b1;
                b_data  = 8'sh96;
            end else if (c == 1) begin
                checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL msbgap in_ready got %b exp 1", b_ready); end
                b_data = 8'sh3C;
            end else begin
                b_valid = 1'b0;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  w [4];
        logic [31:0] seq;
        logic ef, el, eb;
        int idx;
        w[0] = 8'h35; w[1] = 8'hCA; w[2] = 8'h0F; w[3] = 8'h80;
        seq = 32'b10101100_01010011_11110000_00000001;
        idx = 0;
        for (int c = 0; c < 36; c++) begin
            @(negedge clk);
            ef = (c >= 2 && c <= 33);
            el = (c == 9) || (c == 17) || (c == 25) || (c == 33);
            eb = ef ? seq[31-(c-2)] : 1'b0;
            checks++; if (c_frame !== ef) begin errors++; $display("FAIL b2b frame c=%0d got %b exp %b", c, c_frame, ef); end
            checks++; if (c_last !== el)  begin errors++; $display("FAIL b2b last c=%0d got %b exp %b", c, c_last, el); end
            checks++; if (c_sout !== eb)  begin errors++; $display("FAIL b2b a_out c=%0d got %b exp %b", c, c_sout, eb); end
            if (c == 3 || c == 11) begin
                checks++; if (c_ready !== 1'b0) begin errors++; $display("FAIL b2b in_ready full c=%0d got %b exp 0", c, c_ready); end
            end
            if (c == 10 || c == 18) begin
                checks++; if (c_ready !== 1'b1) begin errors++; $display("FAIL b2b in_ready freed c=%0d got %b exp 1", c, c_ready); end
            end
            if (c == 34) begin
                checks++; if (c_busy !== 1'b0) begin errors++; $display("FAIL b2b busy end got %b exp 0", c_busy); end
            end
            if (idx < 4) begin
                c_valid = 1'b1;
                c_data  = w[idx];
                if (c_ready) idx++;
            end else begin
                c_valid = 1'b0;
            end
        end
        checks++; if (idx !== 4) begin errors++; $display("FAIL b2b accepted got %0d exp 4", idx); end
    endtask

    task automatic test_reset_midword();
        for (int c = 0; c < 21; c++) begin
            @(negedge clk);
            if (c >= 2 && c <= 5) begin
                checks++; if (a_frame !== 1'b1) begin errors++; $display("FAIL rstmid frame c=%0d got %b exp 1", c, a_frame); end
                checks++; if (a_sout !== 1'b1)  begin errors++; $display("FAIL rstmid a_out c=%0d got %b exp 1", c, a_sout); end
            end
            if (c >= 6) begin
                checks++; if (a_frame !== 1'b0) begin errors++; $display("FAIL rstmid frame after c=%0d got %b exp 0", c, a_frame); end
                checks++; if (a_sout !== 1'b0)  begin errors++; $display("FAIL rstmid a_out after c=%0d got %b exp 0", c, a_sout); end
                checks++; if (a_busy !== 1'b0)  begin errors++; $display("FAIL rstmid busy c=%0d got %b exp 0", c, a_busy); end
                checks++; if (a_ready !== (c != 6)) begin errors++; $display("FAIL rstmid in_ready c=%0d got %b exp %b", c, a_ready, (c != 6)); end
            end
            a_valid = (c <= 1);
            a_data  = (c == 0) ? 8'shFF : 8'sh5A;
            reset   = (c == 5);
        end
    endtask

    task automatic test_width1();
        logic ef, eb, ebusy;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            ef    = (c == 2) || (c == 3);
            eb    = (c == 2);
            ebusy = (c >= 1 && c <= 3);
            checks++; if (d_frame !== ef)   begin errors++; $display("FAIL w1 frame c=%0d got %b exp %b", c, d_frame, ef); end
            checks++; if (d_last !== ef)    begin errors++; $display("FAIL w1 last c=%0d got %b exp %b", c, d_last, ef); end
            checks++; if (d_sout !== eb)    begin errors++; $display("FAIL w1 a_out c=%0d got %b exp %b", c, d_sout, eb); end
            checks++; if (d_busy !== ebusy) begin errors++; $display("FAIL w1 busy c=%0d got %b exp %b", c, d_busy, ebusy); end
            d_valid = (c <= 1);
            d_data  = (c == 0) ? 1'b1 : 1'b0;
        end
    endtask

    initial begin
        reset   = 1'b1;
        a_valid = 1'b0; a_data = '0;
        b_valid = 1'b0; b_data = '0;
        c_valid = 1'b0; c_data = '0;
        d_valid = 1'b0; d_data = '0;
        test_reset();
        test_lsb_first();
        test_msb_gap();
        test_back_to_back();
        test_reset_midword();
        test_width1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
